// File: rtl/led_pkg.sv
// Shared frame constants, widths and state/error encodings for the LED strip receiver.
package led_pkg;

    localparam int unsigned FRAME_W    = 32;
    localparam int unsigned PIX_W      = 24;
    localparam int unsigned BRIGHT_W   = 5;
    localparam int unsigned LED_CNT_W  = 11;
    localparam int unsigned ZERO_CNT_W = 6;
    localparam int unsigned BIT_CNT_W  = 5;

    localparam logic [FRAME_W-1:0] START_FRAME = 32'h0000_0000;
    localparam logic [FRAME_W-1:0] END_FRAME   = 32'hFFFF_FFFF;
    localparam logic [2:0]         LED_HDR     = 3'b111;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ALIGN = 2'd1,
        DATA  = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        BAD_HDR  = 2'd0,
        NO_END   = 2'd1,
        TIMEOUT  = 2'd2,
        OVERFLOW = 2'd3
    } rx_err_t;

    function automatic logic is_led_hdr(input logic [FRAME_W-1:0] frame);
        return frame[31:29] == LED_HDR;
    endfunction

endpackage

// File: rtl/led_rx_sync_edge.sv
// Brings cki/sdi into the clk domain and produces a registered cki rising-edge strobe
// with the sdi sample that belongs to it.
module led_rx_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic i_cki,
    input  logic i_sdi,
    output logic o_cki_rise,
    output logic o_sdi
);

    logic r_cki_m;
    logic r_cki_s;
    logic r_cki_q;
    logic r_sdi_m;
    logic r_sdi_s;
    logic r_rise;
    logic r_sdi_d;

    // sdi is stable across the cki high phase, so the delayed sample lines up with r_rise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cki_m <= 1'b0;
            r_cki_s <= 1'b0;
            r_cki_q <= 1'b0;
            r_sdi_m <= 1'b0;
            r_sdi_s <= 1'b0;
            r_rise  <= 1'b0;
            r_sdi_d <= 1'b0;
        end else begin
            r_cki_m <= i_cki;
            r_cki_s <= r_cki_m;
            r_cki_q <= r_cki_s;
            r_sdi_m <= i_sdi;
            r_sdi_s <= r_sdi_m;
            r_rise  <= r_cki_s & ~r_cki_q;
            r_sdi_d <= r_sdi_s;
        end
    end

    assign o_cki_rise = r_rise;
    assign o_sdi      = r_sdi_d;

endmodule

// File: rtl/led_recv.sv
// LED strip link receiver: aligns on the 32-bit zero start frame, decodes LED frames
// into FIFO writes and checks the trailing all-ones end frame.
module led_recv
    import led_pkg::*;
#(
    parameter int unsigned LED_NUM     = 4,
    parameter int unsigned TIMEOUT_CNT = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_cki,
    input  logic                 i_sdi,
    input  logic                 i_fifo_full,
    output logic                 o_wr,
    output logic [PIX_W-1:0]     o_wr_data,
    output logic [BRIGHT_W-1:0]  o_wr_bright,
    output logic                 o_frame_done,
    output logic [LED_CNT_W-1:0] o_led_cnt,
    output logic                 o_err,
    output logic [1:0]           o_err_code,
    output logic                 o_busy
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CNT + 1);

    logic w_rise;
    logic w_sdi;

    led_rx_sync_edge u_sync (
        .clk        (clk),
        .rstn       (rstn),
        .i_cki      (i_cki),
        .i_sdi      (i_sdi),
        .o_cki_rise (w_rise),
        .o_sdi      (w_sdi)
    );

    rx_state_t             r_state;
    logic [FRAME_W-1:0]    r_shift;
    logic [ZERO_CNT_W-1:0] r_zero_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [LED_CNT_W-1:0]  r_led_cnt;
    logic [IDLE_W-1:0]     r_idle_cnt;
    logic                  r_wr;
    logic [PIX_W-1:0]      r_wr_data;
    logic [BRIGHT_W-1:0]   r_wr_bright;
    logic                  r_frame_done;
    logic                  r_err;
    rx_err_t               r_err_code;
    logic                  r_busy;

    rx_state_t             w_state_n;
    logic [FRAME_W-1:0]    w_shift_n;
    logic [ZERO_CNT_W-1:0] w_zero_cnt_n;
    logic [BIT_CNT_W-1:0]  w_bit_cnt_n;
    logic [LED_CNT_W-1:0]  w_led_cnt_n;
    logic [IDLE_W-1:0]     w_idle_cnt_n;
    logic                  w_wr_n;
    logic [PIX_W-1:0]      w_wr_data_n;
    logic [BRIGHT_W-1:0]   w_wr_bright_n;
    logic                  w_frame_done_n;
    logic                  w_err_n;
    rx_err_t               w_err_code_n;

    logic [FRAME_W-1:0]    w_frame;
    logic                  w_timeout;

    assign w_frame   = {r_shift[FRAME_W-2:0], w_sdi};
    // A rise in the same cycle always beats the timeout
    assign w_timeout = !w_rise && (r_state != HUNT) &&
                       (r_idle_cnt == IDLE_W'(TIMEOUT_CNT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= HUNT;
            r_shift      <= '0;
            r_zero_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_led_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_wr         <= 1'b0;
            r_wr_data    <= '0;
            r_wr_bright  <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= BAD_HDR;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_shift      <= w_shift_n;
            r_zero_cnt   <= w_zero_cnt_n;
            r_bit_cnt    <= w_bit_cnt_n;
            r_led_cnt    <= w_led_cnt_n;
            r_idle_cnt   <= w_idle_cnt_n;
            r_wr         <= w_wr_n;
            r_wr_data    <= w_wr_data_n;
            r_wr_bright  <= w_wr_bright_n;
            r_frame_done <= w_frame_done_n;
            r_err        <= w_err_n;
            r_err_code   <= w_err_code_n;
            r_busy       <= (w_state_n != HUNT);
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_shift_n      = r_shift;
        w_zero_cnt_n   = r_zero_cnt;
        w_bit_cnt_n    = r_bit_cnt;
        w_led_cnt_n    = r_led_cnt;
        w_idle_cnt_n   = r_idle_cnt;
        w_wr_n         = 1'b0;
        w_wr_data_n    = r_wr_data;
        w_wr_bright_n  = r_wr_bright;
        w_frame_done_n = 1'b0;
        w_err_n        = 1'b0;
        w_err_code_n   = r_err_code;

        if (w_rise) begin
            w_shift_n = w_frame;
        end

        if (r_state == HUNT || w_rise) begin
            w_idle_cnt_n = '0;
        end else begin
            w_idle_cnt_n = r_idle_cnt + IDLE_W'(1);
        end

        case (r_state)
            HUNT: begin
                if (w_rise) begin
                    if (w_sdi == START_FRAME[0]) begin
                        if (r_zero_cnt == ZERO_CNT_W'(FRAME_W - 1)) begin
                            w_zero_cnt_n = ZERO_CNT_W'(FRAME_W);
                            w_state_n    = ALIGN;
                        end else begin
                            w_zero_cnt_n = r_zero_cnt + ZERO_CNT_W'(1);
                        end
                    end else begin
                        w_zero_cnt_n = '0;
                    end
                end
            end
            ALIGN: begin
                // Extra zeros are start padding; the first one is bit 31 of LED frame 0
                if (w_rise && w_sdi) begin
                    w_bit_cnt_n = BIT_CNT_W'(1);
                    w_led_cnt_n = '0;
                    w_state_n   = DATA;
                end else if (w_timeout) begin
                    w_state_n = HUNT;
                end
            end
            DATA: begin
                if (w_rise) begin
                    if (r_bit_cnt == BIT_CNT_W'(FRAME_W - 1)) begin
                        w_bit_cnt_n = '0;
                        if (r_led_cnt < LED_CNT_W'(LED_NUM)) begin
                            if (is_led_hdr(w_frame)) begin
                                w_led_cnt_n = r_led_cnt + LED_CNT_W'(1);
                                if (!i_fifo_full) begin
                                    w_wr_n        = 1'b1;
                                    w_wr_data_n   = w_frame[PIX_W-1:0];
                                    w_wr_bright_n = w_frame[28:24];
                                end else begin
                                    w_err_n      = 1'b1;
                                    w_err_code_n = OVERFLOW;
                                end
                            end else begin
                                w_err_n      = 1'b1;
                                w_err_code_n = BAD_HDR;
                                w_state_n    = HUNT;
                            end
                        end else if (w_frame == END_FRAME) begin
                            w_frame_done_n = 1'b1;
                            w_state_n      = HUNT;
                        end else begin
                            w_err_n      = 1'b1;
                            w_err_code_n = NO_END;
                            w_state_n    = HUNT;
                        end
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end else if (w_timeout) begin
                    w_err_n      = 1'b1;
                    w_err_code_n = TIMEOUT;
                    w_state_n    = HUNT;
                end
            end
            default: begin
                w_state_n = HUNT;
            end
        endcase

        // Re-sync always needs a fresh run of 32 zeros
        if (w_state_n == HUNT && r_state != HUNT) begin
            w_zero_cnt_n = '0;
            w_bit_cnt_n  = '0;
        end
    end

    assign o_wr         = r_wr;
    assign o_wr_data    = r_wr_data;
    assign o_wr_bright  = r_wr_bright;
    assign o_frame_done = r_frame_done;
    assign o_led_cnt    = r_led_cnt;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_led_recv.sv
// Directed bench for led_recv: drives the two-wire line bit by bit and checks the
// FIFO writes, end-of-packet pulses and error reports against hand-computed values.
module tb_led_recv;

    logic        clk;
    logic        rstn;
    logic        i_cki;
    logic        i_sdi;
    logic        i_fifo_full;
    logic        o_wr;
    logic [23:0] o_wr_data;
    logic [4:0]  o_wr_bright;
    logic        o_frame_done;
    logic [10:0] o_led_cnt;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_busy;

    led_recv #(.LED_NUM(4), .TIMEOUT_CNT(64)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_cki        (i_cki),
        .i_sdi        (i_sdi),
        .i_fifo_full  (i_fifo_full),
        .o_wr         (o_wr),
        .o_wr_data    (o_wr_data),
        .o_wr_bright  (o_wr_bright),
        .o_frame_done (o_frame_done),
        .o_led_cnt    (o_led_cnt),
        .o_err        (o_err),
        .o_err_code   (o_err_code),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #3 clk = ~clk;

    int          total;
    int          bad;
    int          n_wr;
    int          n_err;
    int          n_done;
    logic [1:0]  last_code;
    logic [23:0] wr_log [0:63];
    logic [4:0]  br_log [0:63];

    localparam logic [31:0] P0 = 32'hFF11_2233;
    localparam logic [31:0] P1 = 32'hFF44_5566;
    localparam logic [31:0] P2 = 32'hFF77_8899;
    localparam logic [31:0] P3 = 32'hFFAA_BBCC;

    // Event monitor, sampled on the falling clk edge
    initial begin
        n_wr = 0; n_err = 0; n_done = 0; last_code = 2'd0;
        forever begin
            @(negedge clk);
            if (o_wr) begin
                wr_log[n_wr % 64] = o_wr_data;
                br_log[n_wr % 64] = o_wr_bright;
                n_wr++;
            end
            if (o_err) begin
                n_err++;
                last_code = o_err_code;
            end
            if (o_frame_done) n_done++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        i_sdi = b;
        repeat (4) @(posedge clk);
        #1 i_cki = 1'b1;
        repeat (4) @(posedge clk);
        #1 i_cki = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic send_packet(input int pad);
        send_zeros(pad);
        send_word(P0);
        send_word(P1);
        send_word(P2);
        send_word(P3);
        send_word(32'hFFFF_FFFF);
        repeat (8) @(posedge clk);
    endtask

    task automatic chk_full_packet(input string tag, input int wb, input int eb, input int db);
        chk({tag, "_nwr"}, 32'(n_wr - wb), 32'd4);
        chk({tag, "_d0"}, {8'h0, wr_log[(wb + 0) % 64]}, {8'h0, P0[23:0]});
        chk({tag, "_d1"}, {8'h0, wr_log[(wb + 1) % 64]}, {8'h0, P1[23:0]});
        chk({tag, "_d2"}, {8'h0, wr_log[(wb + 2) % 64]}, {8'h0, P2[23:0]});
        chk({tag, "_d3"}, {8'h0, wr_log[(wb + 3) % 64]}, {8'h0, P3[23:0]});
        chk({tag, "_br"}, {27'h0, br_log[(wb + 3) % 64]}, 32'h1F);
        chk({tag, "_done"}, 32'(n_done - db), 32'd1);
        chk({tag, "_nerr"}, 32'(n_err - eb), 32'd0);
        chk({tag, "_ledcnt"}, {21'h0, o_led_cnt}, 32'd4);
        chk({tag, "_busy"}, {31'h0, o_busy}, 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr"}, {31'h0, o_wr}, 32'd0);
        chk({tag, "_data"}, {8'h0, o_wr_data}, 32'd0);
        chk({tag, "_bright"}, {27'h0, o_wr_bright}, 32'd0);
        chk({tag, "_done"}, {31'h0, o_frame_done}, 32'd0);
        chk({tag, "_ledcnt"}, {21'h0, o_led_cnt}, 32'd0);
        chk({tag, "_err"}, {31'h0, o_err}, 32'd0);
        chk({tag, "_code"}, {30'h0, o_err_code}, 32'd0);
        chk({tag, "_busy"}, {31'h0, o_busy}, 32'd0);
    endtask

    int wb;
    int eb;
    int db;

    initial begin
        total = 0; bad = 0;
        rstn = 1'b0; i_cki = 1'b0; i_sdi = 1'b0; i_fifo_full = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        #1 rstn = 1'b1;
        repeat (4) @(posedge clk);

        // Plain packet
        wb = n_wr; eb = n_err; db = n_done;
        send_packet(32);
        chk_full_packet("basic", wb, eb, db);

        // Extra start padding absorbed in ALIGN
        wb = n_wr; eb = n_err; db = n_done;
        send_packet(40);
        chk_full_packet("pad40", wb, eb, db);

        // Bad header on the second LED frame
        wb = n_wr; eb = n_err; db = n_done;
        send_zeros(32);
        send_word(P0);
        send_word(32'h5F00_0000);
        repeat (8) @(posedge clk);
        chk("badhdr_nwr", 32'(n_wr - wb), 32'd1);
        chk("badhdr_nerr", 32'(n_err - eb), 32'd1);
        chk("badhdr_code", {30'h0, last_code}, 32'd0);
        chk("badhdr_busy", {31'h0, o_busy}, 32'd0);
        chk("badhdr_done", 32'(n_done - db), 32'd0);
        wb = n_wr; eb = n_err; db = n_done;
        send_packet(32);
        chk_full_packet("after_bad", wb, eb, db);

        // All-ones pixel in LED position, then missing end frame
        wb = n_wr; eb = n_err; db = n_done;
        send_zeros(32);
        send_word(P0);
        send_word(32'hFFFF_FFFF);
        send_word(P2);
        send_word(P3);
        send_word(32'h0000_0000);
        repeat (8) @(posedge clk);
        chk("noend_nwr", 32'(n_wr - wb), 32'd4);
        chk("noend_white", {8'h0, wr_log[(wb + 1) % 64]}, 32'h00FF_FFFF);
        chk("noend_white_br", {27'h0, br_log[(wb + 1) % 64]}, 32'h1F);
        chk("noend_nerr", 32'(n_err - eb), 32'd1);
        chk("noend_code", {30'h0, last_code}, 32'd1);
        chk("noend_done", 32'(n_done - db), 32'd0);
        chk("noend_ledcnt", {21'h0, o_led_cnt}, 32'd4);

        // cki stalls 10 bits into LED frame 2
        wb = n_wr; eb = n_err; db = n_done;
        send_zeros(32);
        send_word(P0);
        send_word(P1);
        for (int i = 31; i >= 22; i--) send_bit(P2[i]);
        chk("to_busy_before", {31'h0, o_busy}, 32'd1);
        repeat (70) @(posedge clk);
        chk("to_nerr", 32'(n_err - eb), 32'd1);
        chk("to_code", {30'h0, last_code}, 32'd2);
        chk("to_busy", {31'h0, o_busy}, 32'd0);
        chk("to_nwr", 32'(n_wr - wb), 32'd2);
        wb = n_wr; eb = n_err; db = n_done;
        send_packet(32);
        chk_full_packet("after_to", wb, eb, db);

        // FIFO full across pixel 3
        wb = n_wr; eb = n_err; db = n_done;
        send_zeros(32);
        send_word(P0);
        send_word(P1);
        i_fifo_full = 1'b1;
        send_word(P2);
        i_fifo_full = 1'b0;
        send_word(P3);
        send_word(32'hFFFF_FFFF);
        repeat (8) @(posedge clk);
        chk("ovf_nwr", 32'(n_wr - wb), 32'd3);
        chk("ovf_d0", {8'h0, wr_log[(wb + 0) % 64]}, {8'h0, P0[23:0]});
        chk("ovf_d1", {8'h0, wr_log[(wb + 1) % 64]}, {8'h0, P1[23:0]});
        chk("ovf_d2", {8'h0, wr_log[(wb + 2) % 64]}, {8'h0, P3[23:0]});
        chk("ovf_nerr", 32'(n_err - eb), 32'd1);
        chk("ovf_code", {30'h0, last_code}, 32'd3);
        chk("ovf_done", 32'(n_done - db), 32'd1);
        chk("ovf_ledcnt", {21'h0, o_led_cnt}, 32'd4);

        // Reset in the middle of LED frame 0
        wb = n_wr; eb = n_err; db = n_done;
        send_zeros(32);
        for (int i = 31; i >= 17; i--) send_bit(P0[i]);
        chk("mid_busy_before", {31'h0, o_busy}, 32'd1);
        #1 rstn = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (80) @(posedge clk);
        chk("midrst_nwr", 32'(n_wr - wb), 32'd0);
        chk("midrst_nerr", 32'(n_err - eb), 32'd0);
        chk("midrst_busy", {31'h0, o_busy}, 32'd0);
        wb = n_wr; eb = n_err; db = n_done;
        send_packet(32);
        chk_full_packet("after_rst", wb, eb, db);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_recv.md
Name: led_recv

Overview:
- Receiver end of the two-wire LED strip link: clock line cki plus data line sdi. Frame format: a 32-bit start frame of 0; then LED_NUM LED frames {3'b111, bright[4:0], B[7:0], G[7:0], R[7:0]}, MSB first; then a 32-bit end frame of 1s.
- Oversamples cki/sdi on the 150 MHz system clock, aligns to the start frame, and decodes each LED frame.
- Pushes each decoded pixel into a downstream FIFO as {B,G,R}, the same packing the transmit side reads.
- Used as the loopback checker and strip emulator for the LED PHY.

Parameters:
- LED_NUM, 4, number of LED frames expected between the start frame and the end frame.
- TIMEOUT_CNT, 64, clk cycles without a cki rising edge before an in-progress frame is aborted.

Ports:
- clk  in  1  system clock, 150 MHz
- rstn  in  1  asynchronous active-low reset
- cki  in  1  serial clock from the line; asynchronous to clk
- sdi  in  1  serial data from the line; changes on the cki falling edge
- fifo_full  in  1  downstream FIFO full
- wr  out  1  single-cycle FIFO write strobe
- wr_data  out  24  pixel {B,G,R}, equal to LED frame bits [23:0]
- wr_bright  out  5  brightness field, LED frame bits [28:24]
- frame_done  out  1  single-cycle pulse after a valid end frame
- led_cnt  out  11  LED frames accepted in the current or last packet
- err  out  1  single-cycle error pulse
- err_code  out  2  error type, valid while err=1: 0 BAD_HDR, 1 NO_END, 2 TIMEOUT, 3 OVERFLOW
- busy  out  1  high whenever the state is not HUNT

Behaviour:
- Reset: every output 0; state HUNT; all counters 0.
- Input path: cki and sdi each pass a 2-FF synchronizer. cki_rise = cki_s & ~cki_q. On cki_rise, sdi_s is shifted into a 32-bit register, MSB first.
- Line timing: cki high and low phases must each be at least 3 clk.
- Latency: wr rises 4 clk after the pin-level cki rising edge of bit 31 (2 sync, 1 edge register, 1 output register).
- HUNT state:
  - zero_cnt (6b) counts consecutive 0 bits. A 1 bit clears it.
  - zero_cnt saturates at 32; when it reaches 32, go to ALIGN.
- ALIGN state:
  - Further 0 bits are extra start padding and are ignored.
  - The first 1 bit starts LED frame 0: bit_cnt=1, go to DATA.
- DATA state:
  - bit_cnt counts 0..31. On the rise that completes bit 31, the frame is decoded.
  - If led_cnt < LED_NUM:
    - Header [31:29] == 3'b111: emit a pixel, led_cnt++.
    - Any other header: err with BAD_HDR, go to HUNT.
    - An all-ones frame in this position is a valid pixel (0x1F bright, white). It is never treated as an end frame.
  - If led_cnt == LED_NUM:
    - Frame == 32'hFFFF_FFFF: frame_done pulse, go to HUNT. led_cnt holds its value until the next start of frame 0.
    - Otherwise: err with NO_END, go to HUNT.
  - LED_NUM == 0: the first frame after ALIGN is checked as the end frame. A leading 1 is required to leave ALIGN.
- Pixel emit:
  - If fifo_full=0: wr=1 for one clk, with wr_data and wr_bright registered from the shift register.
  - If fifo_full=1: no wr; err with OVERFLOW. led_cnt still increments and reception continues.
- Timeout:
  - idle_cnt counts clk cycles since the last cki_rise while in ALIGN or DATA. It is cleared on every rise and whenever the state is HUNT.
  - In DATA, when idle_cnt reaches TIMEOUT_CNT: err with TIMEOUT, go to HUNT, clear bit_cnt and zero_cnt.
  - In ALIGN, reaching TIMEOUT_CNT returns to HUNT silently; the line is idling after the start frame.
- Simultaneous events:
  - Timeout and a cki_rise in the same clk: the rise wins and the timeout is not reported.
  - Only one err fires per clk. Overflow cannot coincide with any other error.
- Returning to HUNT always clears zero_cnt. Re-sync needs a fresh run of 32 zeros, so trailing 1s are never misread.
- Reset mid-frame: immediate return to reset values. No wr or err is emitted.

Decomposition:
- Package led_pkg holds:
  - START_FRAME = 32'h0000_0000
  - END_FRAME = 32'hFFFF_FFFF
  - LED_HDR = 3'b111
  - enum rx_state_t {HUNT, ALIGN, DATA}
  - enum rx_err_t {BAD_HDR, NO_END, TIMEOUT, OVERFLOW}
- One sub-module, led_rx_sync_edge: 2-FF synchronizers for cki and sdi, plus the cki_rise strobe and aligned sdi_s.

Test Plan:
- Loopback from the LED serializer (DIV_CNT=5), FIFO supplying 0x112233, 0x445566, 0x778899, 0xAABBCC -> 4 wr in that order, wr_bright=5'h1F, then frame_done with led_cnt=4, no err.
- 40 zero bits, then 4 LED frames, then an end frame -> identical wr sequence; the extra zeros are absorbed in ALIGN.
- Second LED frame 0x5F00_0000 -> exactly 1 wr (first pixel), then err with BAD_HDR, busy=0. A following valid packet is fully received.
- 4 LED frames, the second being 0xFFFF_FFFF, then 32'h0 -> 4 wr (second wr_data=0xFFFFFF), then err with NO_END; frame_done never asserted.
- cki stopped after 10 bits of LED frame 2 for 70 clk -> err with TIMEOUT at idle_cnt=64, busy=0. A subsequent full packet gives 4 wr and frame_done.
- fifo_full held across pixel 3 -> wr for pixels 1, 2 and 4 only, one OVERFLOW err, frame_done with led_cnt=4. Separately, rstn pulsed mid-frame -> all outputs 0, no spurious wr.
